event_sync_n: RTL and testbench

Multi-channel event synchronizer and collector in the `c_clk` domain.
- Each of `CH` asynchronous inputs passes through a `SYNC_STAGES`-deep synchronizer; in practice these are toggles or levels driven from `p_clk`-side logic.
- Each channel is edge-detected per `EDGE_MODE` and produces a one-cycle `pulse_o` strobe.
- Detected events also accumulate in per-channel saturating counters, drained one event at a time through a round-robin valid/ready port.
- Replaces the single-channel toggle synchronizer on the pseudo-sensor status path.

---
 rtl/event_sync_pkg.sv | 31 +++
 rtl/event_sync_n_sync_chain.sv | 23 ++
 rtl/event_sync_n.sv | 154 +++++++++++++++
 tb/tb_event_sync_n.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_sync_pkg.sv
// Shared constants and the round-robin search helper for the event synchronizer.
package event_sync_pkg;

    localparam int unsigned EDGE_TOGGLE = 0;
    localparam int unsigned EDGE_RISE   = 1;
    localparam int unsigned EDGE_FALL   = 2;
    localparam int unsigned MAX_CH      = 32;

    // First set bit of mask at or above ptr, wrapping at n; 0 when mask is empty.
    function automatic int unsigned rr_first(
        input logic [MAX_CH-1:0] mask,
        input int unsigned       ptr,
        input int unsigned       n
    );
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && mask[idx[4:0]]) begin
                rr_first = idx;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/event_sync_n_sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/event_sync_n.sv
// Multi-channel event synchronizer, edge detector and round-robin event collector.
// Define EVENT_SYNC_OVF_EN to enable the sticky per-channel overflow flags.
module event_sync_n
    import event_sync_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned CNT_W       = 4,
    localparam int unsigned CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            c_clk,
    input  logic            arst_c_n,
    input  logic [CH-1:0]   evt_in,
    output logic [CH-1:0]   pulse_o,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    input  logic            evt_ready,
    output logic [CH-1:0]   ovf_o,
    input  logic [CH-1:0]   ovf_clr
);

    localparam int unsigned WU_MAX = SYNC_STAGES + 1;
    localparam int unsigned WU_W   = $clog2(WU_MAX + 1);

    logic [CH-1:0]     w_s;
    logic [CH-1:0]     r_h;
    logic [CH-1:0]     w_det;
    logic [CH-1:0]     w_inc;
    logic [CH-1:0]     w_dec;
    logic [CH-1:0]     w_drop;
    logic [CH-1:0]     w_nz;
    logic [MAX_CH-1:0] w_mask;
    logic [WU_W-1:0]   r_wu;
    logic              w_armed;
    logic              w_hs;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]  r_cnt [CH];

    for (genvar g = 0; g < CH; g++) begin : g_ch
        sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (c_clk),
            .i_rst_n (arst_c_n),
            .i_d     (evt_in[g]),
            .o_q     (w_s[g])
        );
    end

    always_comb begin
        w_det = w_s ^ r_h;
        if (EDGE_MODE == EDGE_RISE) begin
            w_det = w_s & ~r_h;
        end else if (EDGE_MODE == EDGE_FALL) begin
            w_det = ~w_s & r_h;
        end
    end

    // Warm-up: suppress the spurious edge from levels held across reset.
    assign w_armed = (r_wu == WU_W'(WU_MAX));

    always_ff @(posedge c_clk or negedge arst_c_n) begin
        if (!arst_c_n) begin
            r_wu <= '0;
        end else if (!w_armed) begin
            r_wu <= r_wu + WU_W'(1);
        end
    end

    assign w_inc = w_det & {CH{w_armed}};

    always_ff @(posedge c_clk or negedge arst_c_n) begin
        if (!arst_c_n) begin
            r_h     <= '0;
            pulse_o <= '0;
        end else begin
            r_h     <= w_s;
            pulse_o <= w_inc;
        end
    end

    always_comb begin
        w_nz = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_nz[i] = |r_cnt[i];
        end
    end

    assign w_mask    = MAX_CH'(w_nz);
    assign evt_valid = |w_nz;
    assign evt_ch    = CH_W'(rr_first(w_mask, 32'(r_rr_ptr), CH));
    assign w_hs      = evt_valid & evt_ready;

    always_comb begin
        w_dec  = '0;
        w_drop = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_dec[i]  = w_hs && (evt_ch == CH_W'(i));
            w_drop[i] = w_inc[i] & ~w_dec[i] & (&r_cnt[i]);
        end
    end

    // Simultaneous increment and drain cancel; saturated increments are dropped.
    always_ff @(posedge c_clk or negedge arst_c_n) begin
        if (!arst_c_n) begin
            for (int unsigned i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (w_inc[i] && !w_dec[i] && !w_drop[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_ptr_nxt = evt_ch + CH_W'(1);
        if ((32'(evt_ch) + 32'd1) >= CH) begin
            w_ptr_nxt = '0;
        end
    end

    always_ff @(posedge c_clk or negedge arst_c_n) begin
        if (!arst_c_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

`ifdef EVENT_SYNC_OVF_EN
    logic [CH-1:0] r_ovf;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge c_clk or negedge arst_c_n) begin
        if (!arst_c_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_drop | (r_ovf & ~ovf_clr);
        end
    end

    assign ovf_o = r_ovf;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ^ovf_clr;
    assign ovf_o            = '0;
`endif

endmodule

// File: tb/tb_event_sync_n.sv
// Directed bench for event_sync_n: three instances (toggle/rise/fall) checked against an event-level model.
module tb_event_sync_n;

    localparam int SS = 2;
    localparam int NI = 3;
    localparam int MODE [NI] = '{0, 1, 2};
    localparam int CMAX [NI] = '{3, 15, 7};
    localparam int HLEN = 1024;
`ifdef EVENT_SYNC_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] ein_a, ein_b;
    logic       rdy_a, rdy_b;
    logic [3:0] clr_a, clr_b;
    logic [3:0] pulse_a, pulse_b, pulse_c;
    logic       valid_a, valid_b, valid_c;
    logic [1:0] ch_a, ch_b, ch_c;
    logic [3:0] ovf_a, ovf_b, ovf_c;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    event_sync_n #(.CH(4), .SYNC_STAGES(SS), .EDGE_MODE(0), .CNT_W(2)) u_dut_a (
        .c_clk(clk), .arst_c_n(rst_n), .evt_in(ein_a), .pulse_o(pulse_a),
        .evt_valid(valid_a), .evt_ch(ch_a), .evt_ready(rdy_a),
        .ovf_o(ovf_a), .ovf_clr(clr_a));

    event_sync_n #(.CH(4), .SYNC_STAGES(SS), .EDGE_MODE(1), .CNT_W(4)) u_dut_b (
        .c_clk(clk), .arst_c_n(rst_n), .evt_in(ein_b), .pulse_o(pulse_b),
        .evt_valid(valid_b), .evt_ch(ch_b), .evt_ready(rdy_b),
        .ovf_o(ovf_b), .ovf_clr(clr_b));

    event_sync_n #(.CH(4), .SYNC_STAGES(SS), .EDGE_MODE(2), .CNT_W(3)) u_dut_c (
        .c_clk(clk), .arst_c_n(rst_n), .evt_in(ein_b), .pulse_o(pulse_c),
        .evt_valid(valid_c), .evt_ch(ch_c), .evt_ready(rdy_b),
        .ovf_o(ovf_c), .ovf_clr(clr_b));

    // Event-level model: input history indexed by edge number since reset release.
    logic [3:0] m_hist [NI][HLEN];
    int         m_cnt  [NI][4];
    int         m_ptr  [NI];
    logic [3:0] m_ovf  [NI];
    logic [3:0] m_pulse[NI];
    int         m_k;
    bit         t_v, t_hs;
    int         t_ch;
    logic [3:0] t_s, t_h, t_det, t_drop;

    function automatic logic [3:0] in_of(input int i);
        return (i == 0) ? ein_a : ein_b;
    endfunction
    function automatic logic rdy_of(input int i);
        return (i == 0) ? rdy_a : rdy_b;
    endfunction
    function automatic logic [3:0] clr_of(input int i);
        return (i == 0) ? clr_a : clr_b;
    endfunction
    function automatic logic [3:0] pulse_of(input int i);
        return (i == 0) ? pulse_a : (i == 1) ? pulse_b : pulse_c;
    endfunction
    function automatic logic valid_of(input int i);
        return (i == 0) ? valid_a : (i == 1) ? valid_b : valid_c;
    endfunction
    function automatic logic [1:0] ch_of(input int i);
        return (i == 0) ? ch_a : (i == 1) ? ch_b : ch_c;
    endfunction
    function automatic logic [3:0] ovf_of(input int i);
        return (i == 0) ? ovf_a : (i == 1) ? ovf_b : ovf_c;
    endfunction

    function automatic logic [3:0] in_at(input int i, input int k);
        if (k <= 0) return 4'b0000;
        return m_hist[i][k];
    endfunction

    function automatic bit m_valid(input int i);
        for (int c = 0; c < 4; c++) if (m_cnt[i][c] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_ch(input int i);
        for (int k = 0; k < 4; k++) begin
            if (m_cnt[i][(m_ptr[i] + k) % 4] > 0) return (m_ptr[i] + k) % 4;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0;
            for (int i = 0; i < NI; i++) begin
                m_ptr[i]   = 0;
                m_ovf[i]   = 4'b0000;
                m_pulse[i] = 4'b0000;
                for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
            end
        end else begin
            if (m_k < HLEN - 1) m_k = m_k + 1;
            for (int i = 0; i < NI; i++) begin
                t_v  = m_valid(i);
                t_ch = m_ch(i);
                t_hs = t_v && rdy_of(i);
                m_hist[i][m_k] = in_of(i);
                t_s = in_at(i, m_k - SS);
                t_h = in_at(i, m_k - SS - 1);
                case (MODE[i])
                    1:       t_det = t_s & ~t_h;
                    2:       t_det = ~t_s & t_h;
                    default: t_det = t_s ^ t_h;
                endcase
                m_pulse[i] = (m_k >= SS + 2) ? t_det : 4'b0000;
                t_drop = 4'b0000;
                for (int c = 0; c < 4; c++) begin
                    if (m_pulse[i][c] && !(t_hs && t_ch == c)) begin
                        if (m_cnt[i][c] == CMAX[i]) t_drop[c] = 1'b1;
                        else m_cnt[i][c] = m_cnt[i][c] + 1;
                    end else if (!m_pulse[i][c] && t_hs && t_ch == c) begin
                        m_cnt[i][c] = m_cnt[i][c] - 1;
                    end
                end
                if (OVF_EN) m_ovf[i] = t_drop | (m_ovf[i] & ~clr_of(i));
                if (t_hs) m_ptr[i] = (t_ch + 1) % 4;
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("pulse_o", i, 32'(pulse_of(i)), 32'(m_pulse[i]));
            chk("evt_valid", i, 32'(valid_of(i)), 32'(m_valid(i)));
            if (m_valid(i)) chk("evt_ch", i, 32'(ch_of(i)), 32'(m_ch(i)));
            chk("ovf_o", i, 32'(ovf_of(i)), 32'(m_ovf[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int hs;

    initial begin
        rst_n = 1'b0;
        ein_a = 4'b0001; ein_b = 4'b0001;
        rdy_a = 1'b0;    rdy_b = 1'b0;
        clr_a = 4'b0000; clr_b = 4'b0000;
        step(3);
        chk("rst_valid", 0, 32'(valid_a), 0);
        chk("rst_ch", 0, 32'(ch_a), 0);
        chk("rst_pulse", 1, 32'(pulse_b), 0);
        rst_n = 1'b1;
        step(10);
        chk("held_high_valid", 0, 32'(valid_a), 0);
        chk("held_high_valid", 1, 32'(valid_b), 0);

        // toggle mode, single event on ch2
        ein_a[2] = 1'b1;
        step(2);
        chk("tog_early_pulse", 0, 32'(pulse_a), 0);
        step(1);
        chk("tog_pulse", 0, 32'(pulse_a), 32'h4);
        chk("tog_valid", 0, 32'(valid_a), 1);
        chk("tog_ch", 0, 32'(ch_a), 2);
        rdy_a = 1'b1;
        step(1);
        chk("tog_drained", 0, 32'(valid_a), 0);
        rdy_a = 1'b0;

        // rising mode round-robin drain
        step(3);
        ein_b[0] = 1'b0;
        step(4);
        ein_b = 4'b1011;
        step(5);
        chk("rr_valid", 1, 32'(valid_b), 1);
        rdy_b = 1'b1;
        chk("rr_first", 1, 32'(ch_b), 0);
        step(1);
        chk("rr_second", 1, 32'(ch_b), 1);
        step(1);
        chk("rr_third", 1, 32'(ch_b), 3);
        step(1);
        chk("rr_empty", 1, 32'(valid_b), 0);
        rdy_b = 1'b0;
        ein_b = 4'b0010;
        step(4);
        ein_b = 4'b1011;
        step(5);
        chk("rr_wrap_ptr", 1, 32'(ch_b), 0);
        rdy_b = 1'b1;
        step(3);
        rdy_b = 1'b0;
        chk("rr_wrap_empty", 1, 32'(valid_b), 0);

        // saturation with CNT_W=2
        for (int n = 0; n < 5; n++) begin
            ein_a[1] = ~ein_a[1];
            step(4);
        end
        chk("sat_valid", 0, 32'(valid_a), 1);
        chk("sat_ch", 0, 32'(ch_a), 1);
        chk("sat_ovf", 0, 32'(ovf_a), OVF_EN ? 32'h2 : 32'h0);
        clr_a[1] = 1'b1;
        step(1);
        clr_a = 4'b0000;
        chk("sat_ovf_clr", 0, 32'(ovf_a), 0);
        hs = 0;
        rdy_a = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (valid_a) hs++;
            step(1);
        end
        rdy_a = 1'b0;
        chk("sat_drain_count", 0, 32'(hs), 3);

        // pulse and handshake on the same edge
        ein_a[0] = 1'b0;
        step(3);
        ein_a[0] = 1'b1;
        step(2);
        rdy_a = 1'b1;
        step(1);
        rdy_a = 1'b0;
        chk("same_pulse", 0, 32'(pulse_a), 32'h1);
        chk("same_valid", 0, 32'(valid_a), 1);
        chk("same_ch", 0, 32'(ch_a), 0);
        step(1);
        chk("same_hold", 0, 32'(valid_a), 1);
        rdy_a = 1'b1;
        step(1);
        rdy_a = 1'b0;
        chk("same_drained", 0, 32'(valid_a), 0);

        // reset mid-drain
        ein_b = 4'b0000;
        step(4);
        ein_b = 4'b1111;
        ein_a[3] = 1'b1;
        step(5);
        chk("pre_rst_valid", 0, 32'(valid_a), 1);
        rdy_b = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 0, 32'(valid_a), 0);
        chk("arst_valid", 1, 32'(valid_b), 0);
        chk("arst_valid", 2, 32'(valid_c), 0);
        chk("arst_pulse", 1, 32'(pulse_b), 0);
        chk("arst_ch", 1, 32'(ch_b), 0);
        step(2);
        rst_n = 1'b1;
        for (int n = 0; n < SS + 1; n++) begin
            step(1);
            chk("warmup_pulse", 0, 32'(pulse_a), 0);
            chk("warmup_pulse", 1, 32'(pulse_b), 0);
        end
        step(6);
        chk("post_rst_valid", 0, 32'(valid_a), 0);
        chk("post_rst_valid", 1, 32'(valid_b), 0);
        rdy_b = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
